// File: rtl/dht11_responder.sv
// dht11_responder: sensor side of the DHT11 single-wire protocol.
// Waits for a host start pulse, answers with the response preamble and then
// serialises a 40-bit frame (4 data bytes + checksum) MSB first by pulse width.
// The bus is open-drain: DHT_oe=1 pulls the line low, DHT_oe=0 releases it.
module dht11_responder #(
    parameter int unsigned START_MIN_CYC = 32'd1800000,
    parameter int unsigned TURN_CYC      = 32'd3000,
    parameter int unsigned RESP_LOW_CYC  = 32'd8000,
    parameter int unsigned RESP_HIGH_CYC = 32'd8000,
    parameter int unsigned BIT_LOW_CYC   = 32'd5000,
    parameter int unsigned BIT0_HIGH_CYC = 32'd2700,
    parameter int unsigned BIT1_HIGH_CYC = 32'd7000,
    parameter int unsigned CNT_W         = 32'd22
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       DHT_in,
    output logic       DHT_oe,
    input  logic       enable,
    input  logic [7:0] hum_int,
    input  logic [7:0] hum_float,
    input  logic [7:0] tmp_int,
    input  logic [7:0] tmp_float,
    input  logic       bad_sum,
    output logic       busy,
    output logic       done,
    output logic       bus_err
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_HOST_LOW  = 3'd1,
        S_TURN      = 3'd2,
        S_RESP_LOW  = 3'd3,
        S_RESP_HIGH = 3'd4,
        S_BIT_LOW   = 3'd5,
        S_BIT_HIGH  = 3'd6,
        S_END_LOW   = 3'd7
    } state_t;

    // Terminal counts: a phase of N cycles ends on the cycle whose count is N-1.
    localparam logic [CNT_W-1:0] START_MIN_C    = CNT_W'(START_MIN_CYC);
    localparam logic [CNT_W-1:0] TURN_LAST      = CNT_W'(TURN_CYC - 32'd1);
    localparam logic [CNT_W-1:0] RESP_LOW_LAST  = CNT_W'(RESP_LOW_CYC - 32'd1);
    localparam logic [CNT_W-1:0] RESP_HIGH_LAST = CNT_W'(RESP_HIGH_CYC - 32'd1);
    localparam logic [CNT_W-1:0] BIT_LOW_LAST   = CNT_W'(BIT_LOW_CYC - 32'd1);
    localparam logic [CNT_W-1:0] BIT0_LAST      = CNT_W'(BIT0_HIGH_CYC - 32'd1);
    localparam logic [CNT_W-1:0] BIT1_LAST      = CNT_W'(BIT1_HIGH_CYC - 32'd1);
    // Our own release needs two sync cycles to show up; the first four cycles
    // of a released phase are therefore not treated as a collision.
    localparam logic [CNT_W-1:0] COLL_GUARD     = CNT_W'(32'd4);

    // Frame checksum: byte sum modulo 256, optionally inverted to inject errors.
    function automatic logic [7:0] frame_checksum(
        input logic [7:0] b0,
        input logic [7:0] b1,
        input logic [7:0] b2,
        input logic [7:0] b3,
        input logic       invert
    );
        logic [7:0] sum;
        sum = b0 + b1 + b2 + b3;
        return invert ? ~sum : sum;
    endfunction

    logic             sync1_q, sync2_q;
    logic             synced_s;
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [39:0]      shift_q, shift_d;
    logic [5:0]       bit_idx_q, bit_idx_d;
    logic             oe_q, oe_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             bus_err_q, bus_err_d;
    logic             collide_s;
    logic [CNT_W-1:0] bit_last_s;

    assign synced_s   = sync2_q;
    assign collide_s  = (cnt_q >= COLL_GUARD) && !synced_s;
    assign bit_last_s = shift_q[39] ? BIT1_LAST : BIT0_LAST;

    assign DHT_oe  = oe_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign bus_err = bus_err_q;

    // Two-flop synchronizer for the asynchronous bus level; idles high like the pulled-up bus.
    always_ff @(posedge CLK) begin
        if (RST) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= DHT_in;
            sync2_q <= sync1_q;
        end
    end

    // State, phase counter, frame shift register and registered outputs.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            shift_q   <= 40'd0;
            bit_idx_q <= 6'd0;
            oe_q      <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            bus_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            shift_q   <= shift_d;
            bit_idx_q <= bit_idx_d;
            oe_q      <= oe_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            bus_err_q <= bus_err_d;
        end
    end

    // Next-state logic: phase sequencing, frame latch/shift and event pulses.
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_idx_d = bit_idx_q;
        done_d    = 1'b0;
        bus_err_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (enable && !synced_s) begin
                    state_d = S_HOST_LOW;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_HOST_LOW: begin
                if (synced_s) begin
                    if (cnt_q >= START_MIN_C) begin
                        state_d = S_TURN;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    state_d = S_HOST_LOW;
                end
            end
            S_TURN: begin
                if (cnt_q == TURN_LAST) begin
                    shift_d   = {hum_int, hum_float, tmp_int, tmp_float,
                                 frame_checksum(hum_int, hum_float, tmp_int, tmp_float, bad_sum)};
                    bit_idx_d = 6'd0;
                    state_d   = S_RESP_LOW;
                end else begin
                    state_d = S_TURN;
                end
            end
            S_RESP_LOW: begin
                if (cnt_q == RESP_LOW_LAST) begin
                    state_d = S_RESP_HIGH;
                end else begin
                    state_d = S_RESP_LOW;
                end
            end
            S_RESP_HIGH: begin
                if (collide_s) begin
                    bus_err_d = 1'b1;
                    state_d   = S_IDLE;
                end else if (cnt_q == RESP_HIGH_LAST) begin
                    state_d = S_BIT_LOW;
                end else begin
                    state_d = S_RESP_HIGH;
                end
            end
            S_BIT_LOW: begin
                if (cnt_q == BIT_LOW_LAST) begin
                    state_d = S_BIT_HIGH;
                end else begin
                    state_d = S_BIT_LOW;
                end
            end
            S_BIT_HIGH: begin
                if (collide_s) begin
                    bus_err_d = 1'b1;
                    state_d   = S_IDLE;
                end else if (cnt_q == bit_last_s) begin
                    shift_d   = {shift_q[38:0], 1'b0};
                    bit_idx_d = bit_idx_q + 6'd1;
                    if (bit_idx_q == 6'd39) begin
                        state_d = S_END_LOW;
                    end else begin
                        state_d = S_BIT_LOW;
                    end
                end else begin
                    state_d = S_BIT_HIGH;
                end
            end
            S_END_LOW: begin
                if (cnt_q == BIT_LOW_LAST) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    state_d = S_END_LOW;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Phase counter: restarts on every state change, otherwise counts up and saturates.
    always_comb begin
        cnt_d = cnt_q;
        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (&cnt_q) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Outputs decoded from the next state so they register in step with it.
    always_comb begin
        oe_d   = 1'b0;
        busy_d = 1'b0;
        case (state_d)
            S_RESP_LOW, S_BIT_LOW, S_END_LOW: begin
                oe_d   = 1'b1;
                busy_d = 1'b1;
            end
            S_RESP_HIGH, S_BIT_HIGH: begin
                oe_d   = 1'b0;
                busy_d = 1'b1;
            end
            default: begin
                oe_d   = 1'b0;
                busy_d = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_dht11_responder.sv
// Bench for dht11_responder with scaled timing. Frames are decoded from the
// DHT_oe pulse widths and compared against a queue of expected frames.
module tb_dht11_responder;

    localparam int LIMIT = 2000;

    logic       clk = 1'b0;
    logic       rst;
    logic       host_low;
    logic       dht_bus;
    logic       dht_oe;
    logic       enable;
    logic [7:0] hum_int, hum_float, tmp_int, tmp_float;
    logic       bad_sum;
    logic       busy, done, bus_err;

    int n_vec = 0;
    int n_err = 0;
    int done_cnt = 0;
    bit tmo;
    logic [39:0] exp_q[$];

    typedef struct {
        logic [7:0]  hi;
        logic [7:0]  hf;
        logic [7:0]  ti;
        logic [7:0]  tf;
        logic        bad;
        logic [39:0] frame;
    } vec_t;
    vec_t vecs[5];

    always #5 clk = ~clk;

    // open-drain bus with pull-up: low if either side pulls
    assign dht_bus = ~(dht_oe | host_low);

    dht11_responder #(
        .START_MIN_CYC(32'd180), .TURN_CYC(32'd30),
        .RESP_LOW_CYC(32'd80),   .RESP_HIGH_CYC(32'd80),
        .BIT_LOW_CYC(32'd50),    .BIT0_HIGH_CYC(32'd27),
        .BIT1_HIGH_CYC(32'd70),  .CNT_W(32'd22)
    ) dut (
        .CLK(clk), .RST(rst), .DHT_in(dht_bus), .DHT_oe(dht_oe),
        .enable(enable), .hum_int(hum_int), .hum_float(hum_float),
        .tmp_int(tmp_int), .tmp_float(tmp_float), .bad_sum(bad_sum),
        .busy(busy), .done(done), .bus_err(bus_err)
    );

    // count done pulses, sampled away from the active edge
    always @(negedge clk) begin
        if (done) done_cnt <= done_cnt + 1;
    end

    task automatic check_int(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_frame(input string name, input logic [39:0] act, input logic [39:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %010h expected %010h", name, act, exp);
        end
    endtask

    // number of cycles DHT_oe stays at lvl, starting at the current negedge
    task automatic run_len(input logic lvl, output int n);
        n = 0;
        while (dht_oe === lvl && n < LIMIT) begin
            n++;
            @(negedge clk);
        end
        if (n >= LIMIT) begin
            tmo = 1'b1;
            check_int("phase_timeout", n, 0);
        end
    endtask

    // host start pulse of 'low' cycles; returns cycles from release to DHT_oe rising
    task automatic host_start(input int low, output int n);
        host_low = 1'b1;
        repeat (low) @(negedge clk);
        host_low = 1'b0;
        n = 0;
        while (dht_oe !== 1'b1 && n < LIMIT) begin
            @(negedge clk);
            n++;
        end
        if (n >= LIMIT) begin
            tmo = 1'b1;
            check_int("start_timeout", n, 0);
        end
    endtask

    task automatic run_vector(input int k, input bit check_turn);
        int n;
        int base;
        logic [39:0] got, exp;
        int hw[40];
        tmo = 1'b0;
        hum_int = vecs[k].hi; hum_float = vecs[k].hf;
        tmp_int = vecs[k].ti; tmp_float = vecs[k].tf;
        bad_sum = vecs[k].bad;
        enable = 1'b1;
        base = done_cnt;
        exp_q.push_back(vecs[k].frame);
        host_start(200, n);
        if (tmo) return;
        // 2 sync flops + 1 decision edge + 30 turnaround cycles
        if (check_turn) check_int("turnaround", n, 33);
        // frame contents are latched; these changes must not show up
        hum_int = 8'($urandom); hum_float = 8'($urandom);
        tmp_int = 8'($urandom); tmp_float = 8'($urandom);
        bad_sum = ~bad_sum;
        enable = 1'b0;
        run_len(1'b1, n); if (tmo) return;
        check_int("resp_low", n, 80);
        run_len(1'b0, n); if (tmo) return;
        check_int("resp_high", n, 80);
        got = 40'd0;
        for (int b = 0; b < 40; b++) begin
            run_len(1'b1, n); if (tmo) return;
            check_int("bit_low", n, 50);
            run_len(1'b0, n); if (tmo) return;
            hw[b] = n;
            got[39-b] = (n > 48);
        end
        run_len(1'b1, n); if (tmo) return;
        check_int("end_low", n, 50);
        check_int("done_at_end", int'(done), 1);
        if (exp_q.size() == 0) begin
            check_int("scoreboard_empty", 0, 1);
        end else begin
            exp = exp_q.pop_front();
            check_frame("frame", got, exp);
            for (int b = 0; b < 40; b++) begin
                check_int("bit_high", hw[b], exp[39-b] ? 70 : 27);
            end
        end
        repeat (3) @(negedge clk);
        check_int("done_once", done_cnt - base, 1);
        enable = 1'b1;
    endtask

    initial begin
        int n;
        bit seen_oe, seen_busy, seen_err;
        int base;

        vecs[0] = '{8'h37, 8'h00, 8'h19, 8'h05, 1'b0, 40'h3700190555};
        vecs[1] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 1'b1, 40'hFFFFFFFF03};
        vecs[2] = '{8'h12, 8'h34, 8'h56, 8'h78, 1'b0, 40'h1234567814};
        vecs[3] = '{8'h00, 8'h00, 8'h00, 8'h00, 1'b1, 40'h00000000FF};
        vecs[4] = '{8'hA5, 8'h5A, 8'h01, 8'h02, 1'b0, 40'hA55A010202};

        rst = 1'b1; host_low = 1'b0; enable = 1'b1;
        hum_int = 8'd0; hum_float = 8'd0; tmp_int = 8'd0; tmp_float = 8'd0;
        bad_sum = 1'b0;
        repeat (4) @(negedge clk);
        check_int("rst_oe", int'(dht_oe), 0);
        check_int("rst_busy", int'(busy), 0);
        check_int("rst_done", int'(done), 0);
        check_int("rst_bus_err", int'(bus_err), 0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // short host pulse is rejected
        host_low = 1'b1;
        repeat (100) @(negedge clk);
        host_low = 1'b0;
        seen_oe = 1'b0; seen_busy = 1'b0;
        repeat (300) begin
            @(negedge clk);
            seen_oe   |= dht_oe;
            seen_busy |= busy;
        end
        check_int("short_oe", int'(seen_oe), 0);
        check_int("short_busy", int'(seen_busy), 0);

        // table of full frames
        for (int k = 0; k < 5; k++) begin
            run_vector(k, k == 0);
            repeat (20) @(negedge clk);
        end

        // collision during the first BIT_HIGH phase
        tmo = 1'b0;
        hum_int = 8'hFF; hum_float = 8'hFF; tmp_int = 8'hFF; tmp_float = 8'hFF;
        bad_sum = 1'b0;
        base = done_cnt;
        host_start(200, n);
        if (!tmo) run_len(1'b1, n);
        if (!tmo) run_len(1'b0, n);
        if (!tmo) run_len(1'b1, n);
        if (!tmo) begin
            repeat (10) @(negedge clk);
            host_low = 1'b1;
            seen_err = 1'b0;
            for (int i = 0; i < 10 && !seen_err; i++) begin
                @(negedge clk);
                seen_err = bus_err;
            end
            check_int("coll_err", int'(seen_err), 1);
            check_int("coll_oe", int'(dht_oe), 0);
            check_int("coll_busy", int'(busy), 0);
            @(negedge clk);
            check_int("coll_err_1cyc", int'(bus_err), 0);
            repeat (5) @(negedge clk);
            host_low = 1'b0;
            seen_oe = 1'b0;
            repeat (300) begin
                @(negedge clk);
                seen_oe |= dht_oe;
            end
            check_int("coll_idle", int'(seen_oe), 0);
            check_int("coll_no_done", done_cnt - base, 0);
        end
        host_low = 1'b0;

        // reset in the middle of bit 20
        tmo = 1'b0;
        hum_int = 8'h12; hum_float = 8'h34; tmp_int = 8'h56; tmp_float = 8'h78;
        base = done_cnt;
        host_start(200, n);
        if (!tmo) run_len(1'b1, n);
        if (!tmo) run_len(1'b0, n);
        for (int b = 0; b < 20 && !tmo; b++) begin
            run_len(1'b1, n);
            if (!tmo) run_len(1'b0, n);
        end
        if (!tmo) begin
            repeat (5) @(negedge clk);
            check_int("pre_rst_oe", int'(dht_oe), 1);
            rst = 1'b1;
            @(negedge clk);
            check_int("mid_rst_oe", int'(dht_oe), 0);
            check_int("mid_rst_busy", int'(busy), 0);
            rst = 1'b0;
            repeat (200) @(negedge clk);
            check_int("mid_rst_no_done", done_cnt - base, 0);
        end
        rst = 1'b0;

        // a normal frame after the aborted one
        run_vector(2, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
